// File: rtl/random_pkg.sv
// Shared constants, FSM state type and LFSR step function for random_ctrl.
package random_pkg;

  localparam int LFSR_W  = 31;
  localparam int TAP_HI  = 30;
  localparam int TAP_MID = 27;
  localparam int TAP_LO  = 5;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'b1000100110101011010111110101011;

  typedef enum logic [1:0] {
    ST_WARM,
    ST_IDLE,
    ST_SHIFT,
    ST_ACK
  } state_e;

  // One Fibonacci step: shift left, feedback from taps 30, 27 and 5.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_MID] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr31.sv
// 31-bit Fibonacci LFSR register with seed load, zero guard and step enable.
module lfsr31
  import random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);

  logic [LFSR_W-1:0] q_q;

  assign q_next = lfsr_step(q_q);
  assign q      = q_q;

  // Register update: reset, then load (all-zero seed replaced by SEED), then step.
  always_ff @(posedge qzt_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      q_q <= SEED;
    end else if (load) begin
      q_q <= (load_val == '0) ? SEED : load_val;
    end else if (en) begin
      q_q <= q_next;
    end
  end

endmodule

// File: rtl/random_ctrl.sv
// Sequencer and round-robin arbiter sharing one LFSR between N_REQ requesters.
module random_ctrl
  import random_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter int                WORD_BITS = 8,
  parameter int                WARMUP    = 64,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic                 qzt_clk,
  input  logic                 reset,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_val,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     ack,
  output logic [WORD_BITS-1:0] data,
  output logic                 busy,
  output logic [LFSR_W-1:0]    lfsr_state
);

  localparam int G_W     = $clog2(N_REQ);
  localparam int CNT_MAX = (WARMUP > WORD_BITS) ? WARMUP : WORD_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WARM_CNT   = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WORD_BITS - 1);
  localparam logic [G_W-1:0]   LAST_RST   = G_W'(N_REQ - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [G_W-1:0]       g_q;
  logic [G_W-1:0]       last_q;
  logic                 drop_q;
  logic [N_REQ-1:0]     ack_q;
  logic [WORD_BITS-1:0] data_q;
  logic                 busy_q;

  logic [LFSR_W-1:0]    lfsr_q;
  logic [LFSR_W-1:0]    lfsr_next;
  logic                 shift_en;
  logic [G_W-1:0]       grant;
  logic [G_W-1:0]       idx;
  logic                 found;
  logic                 unused_next;

  // The LFSR advances only while warming up or producing a word.
  assign shift_en = !seed_load &&
                    (((state_q == ST_WARM) && (cnt_q != WARM_CNT)) || (state_q == ST_SHIFT));

  lfsr31 #(.SEED(SEED)) u_lfsr (
    .qzt_clk  (qzt_clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_val),
    .en       (shift_en),
    .q        (lfsr_q),
    .q_next   (lfsr_next)
  );

  // Only the low WORD_BITS of the next state are delivered.
  assign unused_next = ^lfsr_next;

  // Round-robin pick: first asserted request at or after last+1, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = G_W'((int'(last_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Control FSM with counter, grant pointer and registered outputs.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q <= ST_WARM;
      cnt_q   <= '0;
      g_q     <= '0;
      last_q  <= LAST_RST;
      drop_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b1;
    end else if (seed_load) begin
      // Reseed cancels any grant in flight; the pointer is left alone.
      state_q <= ST_WARM;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_WARM: begin
          if (cnt_q == WARM_CNT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (|req) begin
            g_q     <= grant;
            last_q  <= grant;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SHIFT) begin
            if (drop_q || !req[g_q]) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              data_q  <= lfsr_next[WORD_BITS-1:0];
              ack_q   <= N_REQ'(1) << g_q;
              state_q <= ST_ACK;
            end
          end else if (!req[g_q]) begin
            drop_q <= 1'b1;
          end
        end
        ST_ACK: begin
          ack_q   <= '0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_random_ctrl.sv
// Scoreboard bench for random_ctrl: a transaction-level model predicts the
// grant order and delivered words; a monitor checks every ack against it.
module tb_random_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int WU = 6;
  localparam logic [30:0] SEED_C = 31'b1000100110101011010111110101011;

  logic          qzt_clk = 1'b0;
  logic          reset;
  logic          seed_load;
  logic [30:0]   seed_val;
  logic [N-1:0]  req;

  logic [N-1:0]  ack;
  logic [W-1:0]  data;
  logic          busy;
  logic [30:0]   lfsr_state;

  logic [N-1:0]  ack_w0;
  logic [W-1:0]  data_w0;
  logic          busy_w0;
  logic [30:0]   lfsr_w0;

  random_ctrl #(.N_REQ(N), .WORD_BITS(W), .WARMUP(WU)) u_dut (
    .qzt_clk    (qzt_clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .req        (req),
    .ack        (ack),
    .data       (data),
    .busy       (busy),
    .lfsr_state (lfsr_state)
  );

  random_ctrl #(.N_REQ(N), .WORD_BITS(W), .WARMUP(0)) u_dut_w0 (
    .qzt_clk    (qzt_clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .req        (req),
    .ack        (ack_w0),
    .data       (data_w0),
    .busy       (busy_w0),
    .lfsr_state (lfsr_w0)
  );

  always #5 qzt_clk = ~qzt_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   ack_times[$];

  logic [30:0] m_q;
  int          m_last;

  always @(posedge qzt_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [30:0] step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27] ^ s[5]};
  endfunction

  function automatic int next_rr(input int last, input int mask);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (((mask >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_warm(input logic [30:0] s);
    m_q = (s == 31'd0) ? SEED_C : s;
    repeat (WU) m_q = step(m_q);
  endtask

  // A grant always consumes W shifts; only completed grants deliver a word.
  task automatic model_grant(input int idx, input bit deliver);
    exp_t e;
    repeat (W) m_q = step(m_q);
    m_last = idx;
    if (deliver) begin
      e.idx  = idx;
      e.word = m_q[W-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic model_mask(input int mask);
    int rem;
    int idx;
    rem = mask;
    while (rem != 0) begin
      idx = next_rr(m_last, rem);
      model_grant(idx, 1'b1);
      rem = rem & ~(1 << idx);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge qzt_clk) begin
    if (!reset && ack !== '0) begin
      ack_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {60'd0, ack}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_onehot", {60'd0, ack}, 64'd1 << e.idx);
        check("ack_data", {56'd0, data}, {56'd0, e.word});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge qzt_clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((req != '0 || exp_q.size() != 0) && n < budget) begin
      tick();
      req = req & ~ack;
      n++;
    end
    if (req != '0 || exp_q.size() != 0) begin
      check("serve_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      req = '0;
    end
  endtask

  task automatic serve(input int mask);
    req = N'(mask);
    model_mask(mask);
    wait_done(N * (W + 2) + 20);
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    seed_load = 1'b0;
    seed_val  = '0;
    req       = '0;
    repeat (3) tick();

    // Reset values
    check("rst_lfsr", 64'(lfsr_state), 64'(SEED_C));
    check("rst_ack", {60'd0, ack}, 64'd0);
    check("rst_data", {56'd0, data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_w0_lfsr", 64'(lfsr_w0), 64'(SEED_C));
    check("rst_w0_busy", {63'd0, busy_w0}, 64'd1);

    // Warm-up timing: WARMUP=0 idles after one edge, WARMUP=WU after WU+1
    reset = 1'b0;
    tick();
    check("w0_busy_fall", {63'd0, busy_w0}, 64'd0);
    check("w0_no_shift", 64'(lfsr_w0), 64'(SEED_C));
    check("warm_busy_e1", {63'd0, busy}, 64'd1);
    repeat (WU - 1) tick();
    check("warm_busy_last", {63'd0, busy}, 64'd1);
    tick();
    check("warm_busy_fall", {63'd0, busy}, 64'd0);
    model_warm(SEED_C);
    m_last = N - 1;
    check("warm_lfsr", 64'(lfsr_state), 64'(m_q));

    // All four requesters held: grants 0,1,2,3,0 spaced W+2 apart
    ack_times.delete();
    req = 4'hF;
    for (int k = 0; k < 5; k++) model_grant(next_rr(m_last, 15), 1'b1);
    begin
      int n;
      n = 0;
      while (ack_times.size() < 5 && n < 80) begin
        tick();
        n++;
      end
    end
    req = '0;
    check("held_ack_count", 64'(ack_times.size()), 64'd5);
    for (int k = 1; k < ack_times.size(); k++)
      check("held_spacing", 64'(ack_times[k] - ack_times[k-1]), 64'(W + 2));
    tick();
    tick();

    // Single requester: ack exactly W+1 cycles after acceptance
    begin
      int n;
      req = 4'b0001;
      model_grant(next_rr(m_last, 1), 1'b1);
      n = 0;
      while (ack == '0 && n < 40) begin
        tick();
        n++;
      end
      check("latency", 64'(n), 64'(W + 1));
      req = '0;
      tick();
    end

    // seed_load of zero during SHIFT: no ack, SEED loaded, full warm-up
    req = 4'b0010;
    m_last = next_rr(m_last, 2);
    repeat (4) tick();
    seed_load = 1'b1;
    seed_val  = '0;
    tick();
    seed_load = 1'b0;
    req       = '0;
    check("reseed_lfsr", 64'(lfsr_state), 64'(SEED_C));
    check("reseed_ack", {60'd0, ack}, 64'd0);
    model_warm(31'd0);
    for (int k = 1; k <= WU + 1; k++) begin
      tick();
      check("reseed_busy", {63'd0, busy}, (k <= WU) ? 64'd1 : 64'd0);
    end
    check("reseed_warm_lfsr", 64'(lfsr_state), 64'(m_q));

    // Withdrawn req[2] mid-SHIFT; pending req[3] is served next
    begin
      logic [30:0] mid;
      req = 4'b1100;
      model_grant(next_rr(m_last, 12), 1'b0);
      mid = m_q;
      model_grant(next_rr(m_last, 8), 1'b1);
      repeat (3) tick();
      req[2] = 1'b0;
      repeat (6) tick();
      check("withdraw_idle", {63'd0, busy}, 64'd0);
      check("withdraw_lfsr", 64'(lfsr_state), 64'(mid));
      wait_done(40);
      tick();
    end

    // Randomized traffic with occasional reseeds
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 4) == 0 || r == 7) begin
        logic [30:0] sv;
        sv = (r == 7) ? 31'd0 : 31'($urandom);
        seed_load = 1'b1;
        seed_val  = sv;
        tick();
        seed_load = 1'b0;
        model_warm(sv);
        wait_idle(WU + 5);
        check("rand_reseed_lfsr", 64'(lfsr_state), 64'(m_q));
      end else begin
        serve(int'($urandom_range(1, 15)));
      end
    end

    // Reset on the edge the ack is due
    req = 4'b0001;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_ack", {60'd0, ack}, 64'd0);
    check("rst_mid_lfsr", 64'(lfsr_state), 64'(SEED_C));
    check("rst_mid_data", {56'd0, data}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd1);
    req   = '0;
    reset = 1'b0;
    model_warm(SEED_C);
    m_last = N - 1;
    wait_idle(WU + 5);
    check("rst_mid_warm_lfsr", 64'(lfsr_state), 64'(m_q));
    serve(int'($urandom_range(1, 15)));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/random_ctrl.md
# random_ctrl

Sequencer and arbiter for the 31-bit Fibonacci LFSR random source. It owns seeding, warm-up and stepping of the LFSR, and shares the generator between up to `N_REQ` requesters through a round-robin req/ack handshake. Each grant receives a fresh `WORD_BITS`-bit word produced by `WORD_BITS` dedicated shifts, so no requester ever sees bits already delivered to another. The block sits between the core's consumers of random data and the LFSR datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WORD_BITS`, default 8: bits per delivered word and shifts per grant, 1..31.
- `WARMUP`, default 64: shifts performed after reset or reseed before serving; 0 is legal.
- `SEED`, default 31'b1000100110101011010111110101011: power-on LFSR value.

Ports:
- `qzt_clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `seed_load` in 1: one-cycle pulse that reseeds from `seed_val`.
- `seed_val` in 31: new seed, sampled when `seed_load`=1.
- `req` in `N_REQ`: request lines, level, one per requester.
- `ack` out `N_REQ`: one-hot, one-cycle pulse; `data` is valid while it is high.
- `data` out `WORD_BITS`: delivered word, registered.
- `busy` out 1: high in WARM, SHIFT and ACK.
- `lfsr_state` out 31: current LFSR register, for debug and scoreboarding.

## Operation
- LFSR step: `q <= {q[29:0], q[30]^q[27]^q[5]}`. Shifts happen only in WARM and SHIFT; otherwise `q` holds.
- Zero guard: a load of `seed_val`==0 loads `SEED` instead, because the all-zero state is a lock-up.
- FSM states: WARM, IDLE, SHIFT, ACK.
  - WARM: shift every cycle, `cnt` counts WARMUP shifts, then go to IDLE. If `WARMUP`=0, go to IDLE on the first edge with no shift.
  - IDLE: if any `req` bit is high, latch grant `g`, load `cnt`, and go to SHIFT. No shift happens on the accepting edge.
  - SHIFT: shift every cycle. After `WORD_BITS` shifts, register `data <= q_next[WORD_BITS-1:0]` and `ack[g] <= 1`, and go to ACK.
  - ACK: on the next edge clear `ack` and go to IDLE. `data` holds its value until the next delivery.
- Arbitration: round-robin. Pointer `last` holds the most recent grant. The new grant is the first asserted `req` index starting at `last+1`, modulo `N_REQ`. `last` updates on acceptance.
- Requester rule: hold `req` high until `ack`, then drop it within one cycle. If `req` is still high in IDLE, it counts as a new request.
- Withdrawn request: if `req[g]` falls during SHIFT, the shifts still complete, the state goes to IDLE, and no `ack` is issued. The word is discarded.
- `seed_load` has the highest priority in every state, including the cycle a request would be accepted. It loads the seed, clears `cnt`, forces `ack`=0, and goes to WARM. Any in-flight grant is cancelled without `ack`, and `last` is unchanged.
- Reset values:
  - `q`=`SEED`, state WARM, `cnt`=0.
  - `ack`=0, `data`=0, `busy`=1.
  - `last`=`N_REQ`-1, so the first grant goes to index 0.
- Reset has priority over `seed_load`. Reset asserted mid-operation aborts everything on that edge.

## Timing
- Acceptance edge E0, shifts on E1..E_W with W=`WORD_BITS`. `ack` and `data` are valid in the cycle after E_W, and the state returns to IDLE at E_{W+1}.
- Request-to-ack latency is W+1 cycles after the acceptance edge. A continuously held request is re-served every W+2 cycles.
- After reset is released, `busy` falls WARMUP+1 edges later. The first acceptance can happen on the next edge.
- `busy`, `ack` and `data` are registered, with no combinational path from `req`. `lfsr_state` is the register output directly.

## Structure
- Package `random_pkg` holds:
  - `LFSR_W`=31 and the tap constants 30, 27 and 5.
  - The default seed constant.
  - The FSM state enum.
- Sub-module `lfsr31`: 31-bit register with `load`/`load_val`/`en` inputs and `q`/`q_next` outputs, implementing the step and the zero guard.
- `random_ctrl` contains the FSM, the counter, the round-robin arbiter and the output registers.

## Test plan
- Reset with `WARMUP`=0: `lfsr_state`==`SEED`, `ack`=0, `data`=0, and `busy` falls one cycle after reset is released.
- `req`=4'b0001 held until `ack`: `ack`=4'b0001 exactly 9 cycles after acceptance. `data` equals the model LFSR low 8 bits after 8 shifts from `SEED`.
- `req`=4'b1111 held: grants go 0,1,2,3,0 with acks spaced 10 cycles apart, and no two acks are ever active together.
- `seed_load` with `seed_val`=0 during SHIFT: no `ack`, `lfsr_state`==`SEED` on the next cycle, and `busy` stays high for the full WARMUP period.
- `req[2]` dropped mid-SHIFT: no `ack`, the state returns to IDLE after 8 shifts, and a pending `req[3]` is granted next.
- Reset asserted on the cycle `ack` is due: `ack` stays 0, and all outputs take their reset values.
